// File: rtl/synth_seq_pkg.sv
// synth_seq_pkg: shared types and constants for the note step sequencer
package synth_seq_pkg;
  typedef enum logic [1:0] {IDLE, GATE_ON, GATE_OFF} seq_state_t;
  localparam int FREQ_W_DEF = 24;
  localparam int TEMPO_W_DEF = 16;
  localparam int TICK_W_DEF = 8;
  localparam logic [FREQ_W_DEF-1:0] REST_FREQ = '0;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider emitting a one-cycle tick every div+1 clocks
module tick_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] div,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = cnt == div;
  always_ff @(posedge clk)
    cnt <= (rst || clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/note_step_sequencer.sv
// note_step_sequencer: steps a frequency table with timed gates, or passes manual freq/gate through when stopped
module note_step_sequencer
  import synth_seq_pkg::*;
#(
  parameter int STEPS = 8,
  parameter int FREQ_W = FREQ_W_DEF,
  parameter int TEMPO_W = TEMPO_W_DEF,
  parameter int TICK_W = TICK_W_DEF,
  localparam int AW = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               pat_we,
  input  logic [AW-1:0]      pat_addr,
  input  logic [FREQ_W-1:0]  pat_data,
  input  logic [AW-1:0]      num_steps,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [TICK_W-1:0]  ticks_per_step,
  input  logic [TICK_W-1:0]  gate_ticks,
  input  logic [FREQ_W-1:0]  manual_freq,
  input  logic               manual_gate,
  output logic [FREQ_W-1:0]  freq_out,
  output logic               gate_out,
  output logic [AW-1:0]      step_idx,
  output logic               step_pulse,
  output logic               running
);
  seq_state_t state, state_nx, start_st;
  logic [FREQ_W-1:0] pattern [STEPS];
  logic [FREQ_W-1:0] rd, start_freq, freq_nx;
  logic [AW-1:0] idx_adv, idx_nx;
  logic [TICK_W-1:0] k, k_nx, tps_eff;
  logic [TICK_W:0] k_inc;
  logic tick, step_end, gate_end, gate_nx, pulse_nx, running_nx;

  tick_prescaler #(.W(TEMPO_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .div  (tempo_div),
    .tick (tick)
  );

  assign tps_eff = (ticks_per_step == '0) ? TICK_W'(1) : ticks_per_step;
  assign k_inc = {1'b0, k} + 1'b1;
  assign step_end = tick && (k_inc >= {1'b0, tps_eff});
  assign gate_end = tick && (k_inc >= {1'b0, gate_ticks});
  assign idx_adv = (step_idx >= num_steps) ? '0 : step_idx + 1'b1;
  // Reads see the table before this cycle's write, so a colliding write yields the old entry
  assign rd = pattern[(state == IDLE) ? '0 : idx_adv];
  assign start_st = (rd != FREQ_W'(REST_FREQ) && gate_ticks != '0) ? GATE_ON : GATE_OFF;
  // Rest steps keep the previous frequency so the oscillator does not jump
  assign start_freq = (rd != FREQ_W'(REST_FREQ)) ? rd : freq_out;

  always_comb begin
    state_nx = state;
    idx_nx = step_idx;
    k_nx = k;
    freq_nx = freq_out;
    gate_nx = gate_out;
    pulse_nx = 1'b0;
    running_nx = running;
    if (!run) begin
      state_nx = IDLE;
      idx_nx = '0;
      k_nx = '0;
      freq_nx = manual_freq;
      gate_nx = manual_gate;
      running_nx = 1'b0;
    end else if (state == IDLE || step_end) begin
      state_nx = start_st;
      idx_nx = (state == IDLE) ? '0 : idx_adv;
      k_nx = '0;
      freq_nx = start_freq;
      gate_nx = start_st == GATE_ON;
      pulse_nx = 1'b1;
      running_nx = 1'b1;
    end else if (tick) begin
      k_nx = k + 1'b1;
      state_nx = gate_end ? GATE_OFF : state;
      gate_nx = gate_end ? 1'b0 : gate_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step_idx <= '0;
      k <= '0;
      freq_out <= '0;
      gate_out <= 1'b0;
      step_pulse <= 1'b0;
      running <= 1'b0;
      for (int i = 0; i < STEPS; i++) pattern[i] <= '0;
    end else begin
      state <= state_nx;
      step_idx <= idx_nx;
      k <= k_nx;
      freq_out <= freq_nx;
      gate_out <= gate_nx;
      step_pulse <= pulse_nx;
      running <= running_nx;
      if (pat_we) pattern[pat_addr] <= pat_data;
    end
  end
endmodule

// File: tb/tb_note_step_sequencer.sv
// tb_note_step_sequencer: randomized and directed checks against a position-based reference model
module tb_note_step_sequencer;
  localparam int AW = 3;
  logic clk = 0, rst = 1, run = 0, pat_we = 0, manual_gate = 0;
  logic [AW-1:0] pat_addr = 0, num_steps = 0;
  logic [23:0] pat_data = 0, manual_freq = 0;
  logic [15:0] tempo_div = 0;
  logic [7:0] ticks_per_step = 0, gate_ticks = 0;
  logic [23:0] freq_out;
  logic gate_out, step_pulse, running;
  logic [AW-1:0] step_idx;
  int total = 0, bad = 0;
  int m_pat [8];
  int m_idx, m_pos, m_freq;
  bit m_active, m_gate, m_pulse, m_running, m_play;

  always #5 clk = ~clk;

  note_step_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .num_steps(num_steps), .tempo_div(tempo_div), .ticks_per_step(ticks_per_step),
    .gate_ticks(gate_ticks), .manual_freq(manual_freq), .manual_gate(manual_gate),
    .freq_out(freq_out), .gate_out(gate_out), .step_idx(step_idx), .step_pulse(step_pulse),
    .running(running)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected behaviour from step position: a step lasts L cycles, the gate covers the first G
  task automatic model_update();
    int tps_e, len, glen, v;
    bit start;
    start = 0;
    if (rst) begin
      m_active = 0; m_idx = 0; m_pos = 0; m_freq = 0; m_gate = 0;
      m_pulse = 0; m_running = 0; m_play = 0;
      foreach (m_pat[i]) m_pat[i] = 0;
      return;
    end
    tps_e = (ticks_per_step == 0) ? 1 : int'(ticks_per_step);
    len = tps_e * (int'(tempo_div) + 1);
    glen = ((int'(gate_ticks) < tps_e) ? int'(gate_ticks) : tps_e) * (int'(tempo_div) + 1);
    if (!run) begin
      m_active = 0; m_idx = 0; m_pos = 0; m_freq = int'(manual_freq);
      m_gate = manual_gate; m_pulse = 0; m_running = 0;
    end else begin
      if (!m_active) begin
        m_active = 1; m_idx = 0; m_pos = 0; start = 1;
      end else if (m_pos >= len - 1) begin
        m_idx = (m_idx >= int'(num_steps)) ? 0 : m_idx + 1; m_pos = 0; start = 1;
      end else begin
        m_pos++; m_pulse = 0;
      end
      if (start) begin
        v = m_pat[m_idx];
        if (v != 0) m_freq = v;
        m_play = (v != 0) && (gate_ticks != 0);
        m_pulse = 1; m_running = 1;
      end
      m_gate = m_play && (m_pos < glen);
    end
    if (pat_we) m_pat[pat_addr] = int'(pat_data);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      #1;
      chk("freq_out", 32'(freq_out), 32'(m_freq));
      chk("gate_out", 32'(gate_out), 32'(m_gate));
      chk("step_idx", 32'(step_idx), 32'(m_idx));
      chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
      chk("running", 32'(running), 32'(m_running));
    end
  endtask

  task automatic wr(input int a, input int d);
    pat_we = 1; pat_addr = AW'(a); pat_data = 24'(d);
    cyc(1);
    pat_we = 0;
  endtask

  task automatic cfg(input int div, input int tps, input int gt, input int ns);
    tempo_div = 16'(div); ticks_per_step = 8'(tps); gate_ticks = 8'(gt); num_steps = AW'(ns);
  endtask

  initial begin
    bit found;
    cyc(2);
    rst = 0;
    cyc(2);
    wr(0, 100); wr(1, 200); wr(2, 0);
    cfg(3, 4, 2, 2);
    run = 1; cyc(70);
    run = 0; cyc(2); gate_ticks = 8; run = 1; cyc(70);
    run = 0; cyc(2); gate_ticks = 0; run = 1; cyc(60);
    run = 0; manual_freq = 24'h123456;
    for (int i = 0; i < 10; i++) begin manual_gate = ~manual_gate; cyc(1); end
    gate_ticks = 2; run = 1; cyc(3);
    run = 0; cyc(3);
    run = 1; cyc(20);
    wr(1, 300);
    cyc(70);
    run = 0; cyc(2);
    cfg(2, 0, 1, 2); run = 1; cyc(20);
    run = 0; cyc(2);
    for (int i = 0; i < 8; i++) wr(i, i + 1);
    cfg(0, 1, 1, 7); run = 1;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      cyc(1);
      found = (step_idx == 5) && step_pulse;
    end
    chk("reach_step5", 32'(found), 1);
    num_steps = 1; cyc(1);
    chk("nsteps_wrap", 32'(step_idx), 0);
    cyc(8);
    for (int r = 0; r < 20; r++) begin
      run = 0; cyc(2);
      cfg($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 7));
      for (int i = 0; i < 8; i++) wr(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24'hffffff));
      run = 1;
      for (int c = 0; c < 150; c++) begin
        pat_we = ($urandom_range(0, 15) == 0);
        pat_addr = AW'($urandom);
        pat_data = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
        manual_freq = 24'($urandom);
        manual_gate = 1'($urandom);
        if ($urandom_range(0, 99) == 0) run = 0; else run = 1;
        if ($urandom_range(0, 49) == 0) num_steps = AW'($urandom);
        cyc(1);
      end
      pat_we = 0;
    end
    run = 0; cyc(2);
    wr(0, 100); wr(1, 200); wr(2, 0);
    cfg(3, 4, 2, 2); run = 1; cyc(25);
    rst = 1; cyc(1);
    chk("rst_freq", 32'(freq_out), 0);
    chk("rst_running", 32'(running), 0);
    rst = 0; cyc(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
